// File: rtl/di_fifo_terminal.sv
// di_fifo_terminal: NCH push FIFOs on the DI bus, drained by host reads of per-channel data/status registers
// Ports: if_clock/resetb (async active-low); DI bus diEpAddr, diRegAddr, diRegDataIn, diWrite, diRead,
//   diReset (sync flush); diRegDataOut (registered read data), rdwr_ready (registered read-ahead ready);
//   fabric side push[NCH], push_data[NCH*DW], full[NCH].
module di_fifo_terminal #(
  parameter int          NCH      = 2,
  parameter int          DW       = 16,
  parameter int          DEPTH    = 16,
  parameter logic [15:0] EP_ADDR  = 16'h0000,
  parameter logic [15:0] BASE_REG = 16'h0000,
  parameter logic [15:0] FILL     = 16'hDEAD
) (
  input  logic                if_clock,
  input  logic                resetb,
  input  logic [15:0]         diEpAddr,
  input  logic [15:0]         diRegAddr,
  input  logic [15:0]         diRegDataIn,
  input  logic                diWrite,
  input  logic                diRead,
  input  logic                diReset,
  output logic [15:0]         diRegDataOut,
  output logic                rdwr_ready,
  input  logic [NCH-1:0]      push,
  input  logic [NCH*DW-1:0]   push_data,
  output logic [NCH-1:0]      full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LMAX = (AW+1)'(DEPTH);
  logic [DW-1:0] mem_q [NCH][DEPTH];
  logic [AW-1:0] rd_q [NCH], rd_d [NCH], wr_q [NCH], wr_d [NCH];
  logic [AW:0] lvl_q [NCH], lvl_d [NCH];
  logic [NCH-1:0] ovf_q, ovf_d, udf_q, udf_d, full_q, full_d, we;
  logic [15:0] dout_q, dout_d, head;
  logic [13:0] stat;
  logic rdy_q, rdy_d, sel, dsel, ssel, rd, pop, pu, emp;
  logic unused_wdata;
  assign unused_wdata = ^diRegDataIn[13:0];
  always_comb begin
    sel = diEpAddr == EP_ADDR;
    dout_d = sel ? dout_q : '0;
    rdy_d = 1'b1;
    rd_d = rd_q;
    wr_d = wr_q;
    lvl_d = lvl_q;
    ovf_d = '0;
    udf_d = '0;
    full_d = '0;
    we = '0;
    head = '0;
    stat = '0;
    dsel = 1'b0;
    ssel = 1'b0;
    rd = 1'b0;
    pop = 1'b0;
    pu = 1'b0;
    emp = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      dsel = sel && diRegAddr == BASE_REG + 16'(2*c);
      ssel = sel && diRegAddr == BASE_REG + 16'(2*c+1);
      head = '0;
      head[DW-1:0] = mem_q[c][rd_q[c]];
      stat = '0;
      stat[AW:0] = lvl_q[c];
      emp = lvl_q[c] == '0;
      rd = diRead && dsel;
      pop = rd && !emp;
      // a full channel still accepts a push when the same cycle frees a slot
      pu = push[c] && (lvl_q[c] != LMAX || pop);
      we[c] = pu && !diReset;
      rd_d[c] = diReset ? '0 : rd_q[c] + AW'(pop);
      wr_d[c] = diReset ? '0 : wr_q[c] + AW'(pu);
      lvl_d[c] = diReset ? '0 : lvl_q[c] + (AW+1)'(pu) - (AW+1)'(pop);
      // set events take priority over a same-cycle clear
      ovf_d[c] = !diReset && ((push[c] && !pu) || (ovf_q[c] && !(diWrite && ssel && diRegDataIn[15])));
      udf_d[c] = !diReset && ((rd && emp) || (udf_q[c] && !(diWrite && ssel && diRegDataIn[14])));
      full_d[c] = lvl_d[c] == LMAX;
      if (rd) dout_d = emp ? FILL : head;
      if (diRead && ssel) dout_d = {ovf_q[c], udf_q[c], stat};
      // keep two reads of headroom for reads already in flight
      if (dsel) rdy_d = lvl_d[c] >= (AW+1)'(3);
    end
  end
  always_ff @(posedge if_clock) begin
    for (int c = 0; c < NCH; c++)
      if (we[c]) mem_q[c][wr_q[c]] <= push_data[c*DW +: DW];
  end
  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      dout_q <= '0;
      rdy_q <= 1'b0;
      ovf_q <= '0;
      udf_q <= '0;
      full_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        rd_q[c] <= '0;
        wr_q[c] <= '0;
        lvl_q[c] <= '0;
      end
    end else begin
      dout_q <= dout_d;
      rdy_q <= rdy_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      full_q <= full_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      lvl_q <= lvl_d;
    end
  end
  assign diRegDataOut = dout_q;
  assign rdwr_ready = rdy_q;
  assign full = full_q;
endmodule

// File: tb/tb_di_fifo_terminal.sv
// tb_di_fifo_terminal: scoreboard bench for di_fifo_terminal
module tb_di_fifo_terminal;
  localparam logic [15:0] EP = 16'h0005, BASE = 16'h0010, FILL = 16'hDEAD;
  logic if_clock = 1'b0, resetb = 1'b0;
  logic [15:0] diEpAddr, diRegAddr, diRegDataIn, diRegDataOut, dout8, pd8;
  logic diWrite, diRead, diReset, rdwr_ready, rdy8;
  logic [1:0] push, full, push8, full8;
  logic [31:0] push_data;
  always #5 if_clock = ~if_clock;
  di_fifo_terminal #(.NCH(2), .DW(16), .DEPTH(16), .EP_ADDR(EP), .BASE_REG(BASE), .FILL(FILL)) u_dut (
    .if_clock(if_clock), .resetb(resetb), .diEpAddr(diEpAddr), .diRegAddr(diRegAddr),
    .diRegDataIn(diRegDataIn), .diWrite(diWrite), .diRead(diRead), .diReset(diReset),
    .diRegDataOut(diRegDataOut), .rdwr_ready(rdwr_ready), .push(push), .push_data(push_data), .full(full));
  di_fifo_terminal #(.NCH(2), .DW(8), .DEPTH(16), .EP_ADDR(EP), .BASE_REG(BASE), .FILL(FILL)) u_dut8 (
    .if_clock(if_clock), .resetb(resetb), .diEpAddr(diEpAddr), .diRegAddr(diRegAddr),
    .diRegDataIn(diRegDataIn), .diWrite(diWrite), .diRead(diRead), .diReset(diReset),
    .diRegDataOut(dout8), .rdwr_ready(rdy8), .push(push8), .push_data(pd8), .full(full8));
  typedef struct {logic [15:0] d; logic r; logic [1:0] f;} exp_t;
  exp_t exp_q[$];
  exp_t e_m;
  logic [15:0] mq [2][$];
  logic [1:0] ovf_m, udf_m;
  logic [15:0] dout_m, ep;
  int checks = 0, errors = 0, n;
  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  always @(posedge if_clock) begin
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      #1;
      chk("dout", diRegDataOut, e_m.d);
      chk("rdy", {15'b0, rdwr_ready}, {15'b0, e_m.r});
      chk("full", {14'b0, full}, {14'b0, e_m.f});
    end
  end
  task automatic mreset();
    mq[0].delete();
    mq[1].delete();
    ovf_m = '0;
    udf_m = '0;
    dout_m = '0;
  endtask
  task automatic cyc(input logic rd, input logic wr, input logic dr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] pu, input logic [15:0] p0, input logic [15:0] p1);
    logic s, isd, iss, ld;
    int c;
    logic [15:0] v;
    logic [1:0] pp;
    exp_t e;
    s = ep == EP;
    isd = 0; iss = 0; ld = 0; c = 0; v = '0; pp = '0;
    if (s && a >= BASE && a < BASE + 16'd4) begin
      c = int'(a - BASE) >> 1;
      iss = a[0];
      isd = !a[0];
    end
    if (rd && iss) begin ld = 1; v = {ovf_m[c], udf_m[c], 14'(mq[c].size())}; end
    if (rd && isd) begin
      ld = 1;
      if (mq[c].size() > 0) begin v = mq[c][0]; pp[c] = 1; end
      else v = FILL;
    end
    if (wr && iss) begin
      if (wd[15]) ovf_m[c] = 0;
      if (wd[14]) udf_m[c] = 0;
    end
    if (rd && isd && !pp[c]) udf_m[c] = 1;
    for (int k = 0; k < 2; k++) if (pp[k]) void'(mq[k].pop_front());
    for (int k = 0; k < 2; k++)
      if (pu[k]) begin
        if (mq[k].size() < 16) mq[k].push_back(k ? p1 : p0);
        else ovf_m[k] = 1;
      end
    if (dr) begin mq[0].delete(); mq[1].delete(); ovf_m = '0; udf_m = '0; end
    dout_m = !s ? 16'h0 : ld ? v : dout_m;
    e.d = dout_m;
    e.r = isd ? (mq[c].size() >= 3) : 1'b1;
    e.f = {mq[1].size() == 16, mq[0].size() == 16};
    diEpAddr = ep; diRegAddr = a; diRegDataIn = wd; diRead = rd; diWrite = wr; diReset = dr;
    push = pu; push_data = {p1, p0};
    exp_q.push_back(e);
    @(negedge if_clock);
  endtask
  task automatic idle(input int k);
    repeat (k) cyc(0, 0, 0, 16'h00FF, 16'h0, 2'b00, 16'h0, 16'h0);
  endtask
  task automatic rdd(input logic [15:0] a);
    cyc(1, 0, 0, a, 16'h0, 2'b00, 16'h0, 16'h0);
  endtask
  task automatic wrr(input logic [15:0] a, input logic [15:0] d);
    cyc(0, 1, 0, a, d, 2'b00, 16'h0, 16'h0);
  endtask
  task automatic psh(input logic [1:0] pu, input logic [15:0] p0, input logic [15:0] p1);
    cyc(0, 0, 0, 16'h00FF, 16'h0, pu, p0, p1);
  endtask
  initial begin
    ep = EP;
    diEpAddr = EP; diRegAddr = 16'h00FF; diRegDataIn = '0;
    diWrite = 0; diRead = 0; diReset = 0; push = '0; push_data = '0; push8 = '0; pd8 = '0;
    mreset();
    #1;
    chk("rst_dout", diRegDataOut, 16'h0);
    chk("rst_rdy", {15'b0, rdwr_ready}, 16'h0);
    chk("rst_full", {14'b0, full}, 16'h0);
    chk("rst_dout8", dout8, 16'h0);
    @(negedge if_clock);
    @(negedge if_clock);
    resetb = 1;
    idle(1);
    for (int i = 0; i < 5; i++) psh(2'b01, 16'h0100 + 16'(i), 16'h0);
    rdd(BASE + 16'd1);
    #2 resetb = 0;
    #1;
    chk("arst_dout", diRegDataOut, 16'h0);
    chk("arst_rdy", {15'b0, rdwr_ready}, 16'h0);
    chk("arst_full", {14'b0, full}, 16'h0);
    mreset();
    @(negedge if_clock);
    resetb = 1;
    rdd(BASE + 16'd1);
    for (int i = 1; i <= 16; i++) psh(2'b10, 16'h0, 16'(i));
    n = 0;
    while (rdwr_ready && n < 20) begin
      rdd(BASE + 16'd2);
      n++;
    end
    chk("ndrain", 16'(n), 16'd14);
    rdd(BASE + 16'd3);
    rdd(BASE + 16'd2);
    rdd(BASE + 16'd2);
    idle(1);
    ep = 16'h0000;
    idle(1);
    ep = EP;
    rdd(BASE + 16'd2);
    rdd(BASE + 16'd3);
    wrr(BASE + 16'd3, 16'h4000);
    rdd(BASE + 16'd3);
    psh(2'b10, 16'h0, 16'h1234);
    rdd(BASE + 16'd2);
    for (int i = 0; i < 17; i++) psh(2'b01, 16'h0200 + 16'(i), 16'h0);
    rdd(BASE + 16'd1);
    wrr(BASE + 16'd1, 16'h8000);
    rdd(BASE + 16'd1);
    cyc(0, 1, 0, BASE + 16'd1, 16'h8000, 2'b01, 16'h0BAD, 16'h0);
    rdd(BASE + 16'd1);
    wrr(BASE + 16'd1, 16'h8000);
    cyc(1, 0, 0, BASE, 16'h0, 2'b01, 16'hAAAA, 16'h0);
    rdd(BASE + 16'd1);
    repeat (16) rdd(BASE);
    chk("last_word", diRegDataOut, 16'hAAAA);
    for (int i = 0; i < 4; i++) psh(i < 3 ? 2'b11 : 2'b10, 16'h0300 + 16'(i), 16'h0400 + 16'(i));
    cyc(0, 0, 1, 16'h00FF, 16'h0, 2'b00, 16'h0, 16'h0);
    rdd(BASE + 16'd1);
    rdd(BASE + 16'd3);
    push8 = 2'b10;
    pd8 = 16'hA500;
    psh(2'b10, 16'h0, 16'h5A5A);
    push8 = '0;
    pd8 = '0;
    rdd(BASE + 16'd1);
    rdd(BASE + 16'd3);
    rdd(BASE + 16'd2);
    chk("zext", dout8, 16'h00A5);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/di_fifo_terminal.md
# di_fifo_terminal

Parametrised multi-channel FIFO terminal on the DI bus behind HostInterface. It is the generalised successor to the single-counter fifo/get test registers. Each of NCH channels buffers words pushed by fabric logic; the host drains them through per-channel data registers. Per-channel status registers report fill level and sticky error flags. The block drives rdwr_ready so block reads never under-run.

## Interface
- NCH, 2: number of channels (1..8)
- DW, 16: channel data width (1..16); narrower data zero-extended on diRegDataOut
- DEPTH, 16: entries per channel; power of two, 4..1024
- EP_ADDR, 16'h0000: endpoint address this block answers on
- BASE_REG, 16'h0000: first register address; channel c data = BASE_REG+2c, status = BASE_REG+2c+1
- FILL, 16'hDEAD: value returned on a read of an empty channel
- if_clock  in  1  sole clock; all logic on rising edge
- resetb  in  1  asynchronous, active-low reset
- diEpAddr  in  16  DI endpoint address
- diRegAddr  in  16  DI register address
- diRegDataIn  in  16  DI write data
- diWrite  in  1  one-cycle write strobe
- diRead  in  1  one-cycle read strobe
- diReset  in  1  synchronous flush request
- diRegDataOut  out  16  registered read data; 0 when endpoint not selected
- rdwr_ready  out  1  registered read-ahead ready
- push  in  NCH  per-channel push strobe
- push_data  in  NCH*DW  channel c at [c*DW +: DW]
- full  out  NCH  per-channel full (level == DEPTH), registered

## Operation
- sel = (diEpAddr == EP_ADDR). The data register of channel c is selected when sel and diRegAddr == BASE_REG+2c. Its status register is selected when sel and diRegAddr == BASE_REG+2c+1. All other addresses are ignored.
- Each channel has a circular buffer with rd/wr pointers of log2(DEPTH) bits. Pointers wrap modulo DEPTH. level is log2(DEPTH)+1 bits, range 0..DEPTH.
- Push: push[c] with level<DEPTH writes the entry and increments level.
  - Push at level==DEPTH drops the data and sets ovf[c], unless a pop on c occurs in the same cycle; in that case the push is accepted and level stays DEPTH.
- Pop: diRead on channel c's data register.
  - If level>0: the head is popped and diRegDataOut is loaded with the head on the next edge.
  - If level==0: diRegDataOut is loaded with FILL, udf[c] is set, and pointers and level are unchanged.
- Simultaneous push and pop on a non-empty channel: level is unchanged and both pointers advance.
- Status read: diRead on a status register loads diRegDataOut = {ovf, udf, 14-bit zero-extended level} on the next edge. The level shown is the value before any same-cycle push.
- Status write: diWrite on a status register with diRegDataIn[15]=1 clears ovf; with diRegDataIn[14]=1 it clears udf. Other bits are ignored. Writes to data registers are ignored.
- A set event in the same cycle as a clear leaves the flag set.
- rdwr_ready, evaluated each edge:
  - When a channel's data register is selected: rdwr_ready <= (level_next >= 3), where level_next is the level after this cycle's push/pop. This covers up to 2 reads in flight.
  - All other addresses: rdwr_ready <= 1.
  - Remaining 1–2 words are drained by reading the status level and issuing single reads.
- diReset (synchronous, 1 cycle): all pointers, levels, and flags are cleared, and pushes that cycle are discarded. diRegDataOut and rdwr_ready update normally.
- diRegDataOut <= 0 on any cycle where sel is 0. It holds its value when sel is 1 and no read occurs.

## Timing
- Reset (resetb low, asynchronous): diRegDataOut=0, rdwr_ready=0, full=0, all levels, pointers and flags 0. Outputs take these values immediately.
- The first edge after reset release evaluates rdwr_ready per the rules above.
- Read latency is 1: data for diRead at edge t appears after edge t+1 and is held until the next read or deselect.
- Push to readable takes one cycle: push at edge t makes level_next include the entry, so rdwr_ready can rise after edge t.
- full[c] is valid one cycle after the push/pop that changes level.
- Back-to-back reads on every cycle are supported at full rate while rdwr_ready stays high.

## Test plan
- Reset mid-stream: push 5 words to ch0, assert resetb low between edges -> outputs 0 immediately; after release, ch0 status reads 0x0000.
- Ordered drain: push 0x0001..0x0010 to ch1 (DEPTH=16), then read data on every cycle while rdwr_ready=1 -> returns 0x0001..0x000E in order. rdwr_ready falls when level_next hits 2. Status reads 0x0002, and two single reads return 0x000F and 0x0010.
- Overflow: push 17 words to ch0 with no reads -> full[0]=1, 17th word dropped, status=0x8010. Writing 0x8000 to the status register reads back 0x0010.
- Underflow: read empty ch1 data register -> diRegDataOut=0xDEAD one cycle later, status=0x4000, no pointer change.
- Full with simultaneous push+pop: at level 16, push 0xAAAA while popping -> pop returns the oldest word; level stays 16, ovf stays 0, and 0xAAAA is the last word read out.
- diReset and channel isolation: fill ch0 with 3 words and ch1 with 4 words, then pulse diReset -> both statuses read 0x0000. Afterwards, pushing to ch1 only leaves the ch0 status at 0 and, with DW=8, ch1 data is zero-extended.
